// File: rtl/demux14_stream.sv
// 1-to-4 valid/ready stream demultiplexer with a one-entry holding register per channel.
// Define DEMUX_CNT_EN to add the cnt port with saturating per-channel push counters.
module demux14_stream #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   in_data,
  input  logic [1:0]      in_sel,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [4*DW-1:0] out_data,
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [31:0]     cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_t;

  logic [3:0] push;
  logic [3:0] pop;

  // Only the selected channel can stall the producer; the others drain freely.
  always_comb begin
    in_ready = ~rst & (~out_valid[in_sel] | out_ready[in_sel]);
  end

  for (genvar k = 0; k < 4; k++) begin : g_chan
    chan_state_t   state;
    logic [DW-1:0] data_q;

    assign push[k] = in_valid & in_ready & (in_sel == 2'(k));
    assign pop[k]  = out_valid[k] & out_ready[k];

    // A push while FULL is only possible together with a pop, so a push always
    // leaves the channel FULL; data stays put when the channel empties.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state  <= EMPTY;
        data_q <= '0;
      end else begin
        if (push[k]) begin
          state  <= FULL;
          data_q <= in_data;
        end else if (pop[k]) begin
          state  <= EMPTY;
        end
      end
    end

    assign out_valid[k]          = (state == FULL);
    assign out_data[k*DW +: DW]  = data_q;

`ifdef DEMUX_CNT_EN
    logic [7:0] cnt_q;

    // Saturates instead of wrapping so a busy channel never reads as idle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= 8'h00;
      end else if (push[k] && (cnt_q != 8'hFF)) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end

    assign cnt[k*8 +: 8] = cnt_q;
`endif
  end

endmodule

// File: tb/tb_demux14_stream.sv
// Self-checking bench for demux14_stream: directed steps followed by a random phase,
// all compared against a per-channel occupancy/data model with consumer logs.
module tb_demux14_stream;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   in_data;
  logic [1:0]      in_sel;
  logic            in_valid;
  logic            in_ready;
  logic [4*DW-1:0] out_data;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
`ifdef DEMUX_CNT_EN
  logic [31:0]     cnt;
`endif

  int checks   = 0;
  int failures = 0;

  bit            mValid[4];
  logic [DW-1:0] mData[4];
  int            mPushes[4];
  logic [DW-1:0] recv[4][$];

  bit            checkProtocol = 1'b0;
  bit            lastStall     = 1'b0;
  logic [1:0]    lastSel       = 2'd0;
  logic [DW-1:0] lastData      = '0;

  demux14_stream #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX_CNT_EN
    ,
    .cnt       (cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] expValidVec();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = mValid[k];
    return v;
  endfunction

  function automatic logic [4*DW-1:0] expDataVec();
    return {mData[3], mData[2], mData[1], mData[0]};
  endfunction

  function automatic logic [31:0] expCntVec();
    logic [31:0] c;
    for (int k = 0; k < 4; k++) c[k*8 +: 8] = 8'((mPushes[k] > 255) ? 255 : mPushes[k]);
    return c;
  endfunction

  function automatic bit expReady();
    return !mValid[in_sel] || out_ready[in_sel];
  endfunction

  task automatic clearModel();
    for (int k = 0; k < 4; k++) begin
      mValid[k]  = 1'b0;
      mData[k]   = '0;
      mPushes[k] = 0;
    end
    lastStall = 1'b0;
  endtask

  task automatic checkOutput();
    check("out_valid", 64'(out_valid), 64'(expValidVec()));
    check("out_data",  64'(out_data),  64'(expDataVec()));
    check("in_ready",  64'(in_ready),  64'(expReady()));
`ifdef DEMUX_CNT_EN
    check("cnt",       64'(cnt),       64'(expCntVec()));
`endif
  endtask

  // One clock cycle: drive, check at negedge, then advance the model on the edge.
  task automatic applyStimulus(input bit v, input logic [1:0] s, input logic [DW-1:0] d,
                               input logic [3:0] r);
    bit acc;
    if (checkProtocol && lastStall)
      check("producer_hold", 64'({v, s, d}), 64'({1'b1, lastSel, lastData}));
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    checkOutput();
    acc       = v && expReady();
    lastStall = v && !acc;
    lastSel   = s;
    lastData  = d;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (mValid[k] && r[k]) begin
        recv[k].push_back(mData[k]);
        mValid[k] = 1'b0;
      end
    end
    if (acc) begin
      mValid[s] = 1'b1;
      mData[s]  = d;
      mPushes[s]++;
    end
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    #1;
    clearModel();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data",  64'(out_data),  64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(0));
`ifdef DEMUX_CNT_EN
    check("rst_cnt",       64'(cnt),       64'(0));
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    in_sel = 2'd0;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit            v;
    logic [1:0]    s;
    logic [DW-1:0] d;

    rst = 1'b1;
    in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'h0;
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    check("init_out_valid", 64'(out_valid), 64'(0));
    check("init_in_ready",  64'(in_ready),  64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-stream with channel 2 holding a word.
    applyStimulus(1'b1, 2'd2, 8'h66, 4'h0);
    check("ch2_full_before_rst", 64'(out_valid), 64'(4'b0100));
    in_valid = 1'b0;
    #2;
    pulseReset();

    // Basic route.
    applyStimulus(1'b1, 2'd2, 8'hA5, 4'h0);
    check("route_valid", 64'(out_valid),        64'(4'b0100));
    check("route_data",  64'(out_data[23:16]),  64'(8'hA5));

    // Head-of-line stall on channel 1, then divert to channel 3.
    applyStimulus(1'b1, 2'd1, 8'h3C, 4'h0);
    applyStimulus(1'b1, 2'd1, 8'h77, 4'h0);
    check("stall_ch1_data", 64'(out_data[15:8]), 64'(8'h3C));
    applyStimulus(1'b1, 2'd3, 8'h5E, 4'h0);
    check("divert_ch3_valid", 64'(out_valid[3]),    64'(1));
    check("divert_ch3_data",  64'(out_data[31:24]), 64'(8'h5E));
    check("divert_ch1_data",  64'(out_data[15:8]),  64'(8'h3C));
    applyStimulus(1'b0, 2'd0, 8'h00, 4'hF);

    // Full throughput on channel 0.
    recv[0].delete();
    applyStimulus(1'b1, 2'd0, 8'h01, 4'h0);
    for (int i = 2; i <= 16; i++) applyStimulus(1'b1, 2'd0, 8'(i), 4'b0001);
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b0001);
    check("thru_count", 64'(recv[0].size()), 64'(16));
    for (int i = 0; i < 16 && i < recv[0].size(); i++)
      check("thru_order", 64'(recv[0][i]), 64'(i + 1));

    // Parallel drain of all channels with a simultaneous push to channel 0.
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 2'(k), 8'(8'h90 + k), 4'h0);
    check("all_full", 64'(out_valid), 64'(4'hF));
    applyStimulus(1'b1, 2'd0, 8'hC3, 4'hF);
    check("drain_valid", 64'(out_valid),     64'(4'b0001));
    check("drain_data",  64'(out_data[7:0]), 64'(8'hC3));
    applyStimulus(1'b0, 2'd0, 8'h00, 4'hF);

    // Random traffic under the producer hold rule.
    checkProtocol = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (lastStall) begin
        v = 1'b1; s = lastSel; d = lastData;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        s = 2'($urandom_range(0, 3));
        d = 8'($urandom);
      end
      applyStimulus(v, s, d, 4'($urandom));
    end
    checkProtocol = 1'b0;
    applyStimulus(1'b0, 2'd0, 8'h00, 4'hF);

`ifdef DEMUX_CNT_EN
    pulseReset();
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 2'd3, 8'(i), 4'b1000);
    for (int i = 0; i < 5; i++)   applyStimulus(1'b1, 2'd0, 8'(i), 4'b0001);
    applyStimulus(1'b0, 2'd0, 8'h00, 4'hF);
    check("cnt_ch3_sat", 64'(cnt[31:24]), 64'(8'hFF));
    check("cnt_ch0",     64'(cnt[7:0]),   64'(8'h05));
    pulseReset();
    check("cnt_cleared", 64'(cnt), 64'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
